bp_update_sched: RTL and testbench

- Collects branch-resolution results from two branch execution units (BU0, BU1) and serializes them onto the single update port of the branch history table.
- Sits between the branch units / ROB commit side and the BHT update inputs (BranchEn, BranchMisTaken, misTakenAddr).
- Buffers bursts in a small in-order FIFO. Drains one update per rdy cycle. Applies backpressure to the requesters.

---
 rtl/bp_update_sched_pkg.sv | 17 +
 rtl/bp_update_fifo.sv | 48 ++++
 rtl/bp_update_sched.sv | 97 +++++++++
 tb/tb_bp_update_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_sched_pkg.sv
// Shared definitions for the branch-update scheduler: instruction address width,
// default FIFO depth and the BHT index slice used by misTakenAddr consumers.
package bp_update_sched_pkg;

    localparam int BP_INST_ADDR_W   = 32;
    localparam int BP_DEPTH_DEFAULT = 4;
    localparam int BP_BHT_IDX_HI    = 6;
    localparam int BP_BHT_IDX_LO    = 2;

    // BHT row selected by a branch PC.
    function automatic logic [BP_BHT_IDX_HI-BP_BHT_IDX_LO:0] bht_index(
        input logic [BP_INST_ADDR_W-1:0] addr
    );
        return addr[BP_BHT_IDX_HI:BP_BHT_IDX_LO];
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// In-order circular buffer with two write slots (tail, tail+1) and one read port.
// The caller guarantees writes never exceed the free space.
module bp_update_fifo
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEFAULT,
    parameter int WIDTH = BP_INST_ADDR_W + 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wr_cnt,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic [WIDTH-1:0] wr_data1,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_p1;

    assign tail_p1 = tail + PTR_W'(1);
    assign rd_data = mem[head];

    // NOTE: storage has no reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_cnt != 2'd0) mem[tail]    <= wr_data0;
        if (wr_cnt == 2'd2) mem[tail_p1] <= wr_data1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (rd_en) head <= head + PTR_W'(1);
            tail  <= tail + PTR_W'(wr_cnt);
            count <= count + CNT_W'(wr_cnt) - CNT_W'(rd_en);
        end
    end

endmodule

// File: rtl/bp_update_sched.sv
// Serializes branch resolutions from BU0/BU1 onto the single BHT update port.
// Optional saturating issue counters are enabled by defining BP_UPDATE_STATS_EN.
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH  = BP_DEPTH_DEFAULT,
    parameter int ADDR_W = BP_INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req0En,
    input  logic              req0Mis,
    input  logic [ADDR_W-1:0] req0Addr,
    input  logic              req1En,
    input  logic              req1Mis,
    input  logic [ADDR_W-1:0] req1Addr,
    output logic              acceptRdy,
    output logic              BranchEn,
    output logic              BranchMisTaken,
    output logic [ADDR_W-1:0] misTakenAddr,
`ifdef BP_UPDATE_STATS_EN
    output logic [31:0]       statTotal,
    output logic [31:0]       statMis,
`endif
    output logic              overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  free_after;
    logic [1:0]        n_req;
    logic [1:0]        n_fit;
    logic              deq;
    logic              drop;
    logic [ADDR_W:0]   wr_data0;
    logic [ADDR_W:0]   wr_data1;
    logic [ADDR_W:0]   rd_data;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        deq        = rdy && (count != '0);
        free_after = CNT_W'(DEPTH) - count + CNT_W'(deq);
        n_req      = 2'd0;
        if (rdy) n_req = {1'b0, req0En} + {1'b0, req1En};
        // Short on space: keep the oldest requests, so BU1 is the first dropped.
        n_fit      = (free_after >= CNT_W'(n_req)) ? n_req : free_after[1:0];
        drop       = (n_fit != n_req);
        wr_data0   = req0En ? {req0Mis, req0Addr} : {req1Mis, req1Addr};
        wr_data1   = {req1Mis, req1Addr};
        count_next = count + CNT_W'(n_fit) - CNT_W'(deq);
    end

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_cnt   (n_fit),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rd_en    (deq),
        .rd_data  (rd_data),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BranchEn       <= 1'b0;
            BranchMisTaken <= 1'b0;
            misTakenAddr   <= '0;
            acceptRdy      <= 1'b1;
            overflow       <= 1'b0;
        end else if (rdy) begin
            BranchEn <= deq;
            if (deq) {BranchMisTaken, misTakenAddr} <= rd_data;
            acceptRdy <= (CNT_W'(DEPTH) - count_next) >= CNT_W'(2);
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef BP_UPDATE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statTotal <= '0;
            statMis   <= '0;
        end else if (deq) begin
            if (statTotal != '1) statTotal <= statTotal + 32'd1;
            if (rd_data[ADDR_W] && (statMis != '1)) statMis <= statMis + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched with a queue-based reference model and
// per-cycle comparison; define BP_UPDATE_STATS_EN to also cover the counters.
module tb_bp_update_sched;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              req0En, req0Mis, req1En, req1Mis;
    logic [ADDR_W-1:0] req0Addr, req1Addr;
    logic              acceptRdy, BranchEn, BranchMisTaken, overflow;
    logic [ADDR_W-1:0] misTakenAddr;
`ifdef BP_UPDATE_STATS_EN
    logic [31:0]       statTotal, statMis;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    bp_update_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .req0En         (req0En),
        .req0Mis        (req0Mis),
        .req0Addr       (req0Addr),
        .req1En         (req1En),
        .req1Mis        (req1Mis),
        .req1Addr       (req1Addr),
        .acceptRdy      (acceptRdy),
        .BranchEn       (BranchEn),
        .BranchMisTaken (BranchMisTaken),
        .misTakenAddr   (misTakenAddr),
`ifdef BP_UPDATE_STATS_EN
        .statTotal      (statTotal),
        .statMis        (statMis),
`endif
        .overflow       (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending updates, following the
    // dequeue-first / fit-oldest-first rules directly.
    typedef struct {
        logic              mis;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    ent_t              q[$];
    ent_t              popped;
    logic              m_en, m_mis, m_acc, m_ovf;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_tot, m_miscnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_en = 1'b0; m_mis = 1'b0; m_addr = '0;
            m_acc = 1'b1; m_ovf = 1'b0; m_tot = '0; m_miscnt = '0;
        end else if (rdy) begin
            if (q.size() > 0) begin
                popped = q.pop_front();
                m_en = 1'b1; m_mis = popped.mis; m_addr = popped.addr;
                if (m_tot != '1) m_tot = m_tot + 1;
                if (popped.mis && m_miscnt != '1) m_miscnt = m_miscnt + 1;
            end else begin
                m_en = 1'b0;
            end
            if (req0En) begin
                if (q.size() < DEPTH) q.push_back('{req0Mis, req0Addr});
                else m_ovf = 1'b1;
            end
            if (req1En) begin
                if (q.size() < DEPTH) q.push_back('{req1Mis, req1Addr});
                else m_ovf = 1'b1;
            end
            m_acc = (DEPTH - q.size()) >= 2;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst && cmp_en) begin
            check("model.BranchEn", 64'(BranchEn), 64'(m_en));
            check("model.BranchMisTaken", 64'(BranchMisTaken), 64'(m_mis));
            check("model.misTakenAddr", 64'(misTakenAddr), 64'(m_addr));
            check("model.acceptRdy", 64'(acceptRdy), 64'(m_acc));
            check("model.overflow", 64'(overflow), 64'(m_ovf));
`ifdef BP_UPDATE_STATS_EN
            check("model.statTotal", 64'(statTotal), 64'(m_tot));
            check("model.statMis", 64'(statMis), 64'(m_miscnt));
`endif
        end
    end

    task automatic cyc(input logic r, input logic e0, input logic m0, input logic [ADDR_W-1:0] a0,
                       input logic e1, input logic m1, input logic [ADDR_W-1:0] a1);
        rdy = r;
        req0En = e0; req0Mis = m0; req0Addr = a0;
        req1En = e1; req1Mis = m1; req1Addr = a1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic expect_out(input string tag, input logic en, input logic mis, input logic [ADDR_W-1:0] addr);
        check({tag, ".BranchEn"}, 64'(BranchEn), 64'(en));
        check({tag, ".BranchMisTaken"}, 64'(BranchMisTaken), 64'(mis));
        check({tag, ".misTakenAddr"}, 64'(misTakenAddr), 64'(addr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1;
        req0En = 1'b0; req0Mis = 1'b0; req0Addr = '0;
        req1En = 1'b0; req1Mis = 1'b0; req1Addr = '0;
        @(posedge clk); #1;
        expect_out("reset", 1'b0, 1'b0, '0);
        check("reset.acceptRdy", 64'(acceptRdy), 64'd1);
        check("reset.overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;

        // Single update: visible one cycle after enqueue, then BranchEn drops.
        cyc(1'b1, 1'b1, 1'b1, 32'h1004, 1'b0, 1'b0, '0);
        expect_out("single.enq", 1'b0, 1'b0, '0);
        idle(); expect_out("single.issue", 1'b1, 1'b1, 32'h1004);
        idle(); expect_out("single.after", 1'b0, 1'b1, 32'h1004);

        // Dual same-cycle: BU0 is older.
        cyc(1'b1, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b1, 32'h2008);
        idle(); expect_out("dual.first", 1'b1, 1'b0, 32'h2000);
        idle(); expect_out("dual.second", 1'b1, 1'b1, 32'h2008);
        idle(); expect_out("dual.after", 1'b0, 1'b1, 32'h2008);

        // Backpressure: two bursts leave 3 queued.
        cyc(1'b1, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b1, 32'h3004);
        check("bp.burst1.acceptRdy", 64'(acceptRdy), 64'd1);
        cyc(1'b1, 1'b1, 1'b0, 32'h3008, 1'b1, 1'b1, 32'h300C);
        check("bp.burst2.acceptRdy", 64'(acceptRdy), 64'd0);
        expect_out("bp.d0", 1'b1, 1'b0, 32'h3000);
        idle(); expect_out("bp.d1", 1'b1, 1'b1, 32'h3004);
        check("bp.d1.acceptRdy", 64'(acceptRdy), 64'd1);
        idle(); expect_out("bp.d2", 1'b1, 1'b0, 32'h3008);
        idle(); expect_out("bp.d3", 1'b1, 1'b1, 32'h300C);
        idle(); expect_out("bp.empty", 1'b0, 1'b1, 32'h300C);

        // Overflow: fill to DEPTH, then a dual request with one free slot.
        cyc(1'b1, 1'b1, 1'b0, 32'h4000, 1'b1, 1'b0, 32'h4004);
        cyc(1'b1, 1'b1, 1'b0, 32'h4008, 1'b1, 1'b0, 32'h400C);
        cyc(1'b1, 1'b1, 1'b0, 32'h4010, 1'b1, 1'b0, 32'h4014);
        check("ovf.full.acceptRdy", 64'(acceptRdy), 64'd0);
        check("ovf.full.overflow", 64'(overflow), 64'd0);
        cyc(1'b1, 1'b1, 1'b1, 32'h4018, 1'b1, 1'b0, 32'h401C);
        check("ovf.drop.overflow", 64'(overflow), 64'd1);
        expect_out("ovf.o2", 1'b1, 1'b0, 32'h4008);
        idle(); expect_out("ovf.o3", 1'b1, 1'b0, 32'h400C);
        idle(); expect_out("ovf.o4", 1'b1, 1'b0, 32'h4010);
        idle(); expect_out("ovf.o5", 1'b1, 1'b0, 32'h4014);
        idle(); expect_out("ovf.o6", 1'b1, 1'b1, 32'h4018);
        idle(); expect_out("ovf.empty", 1'b0, 1'b1, 32'h4018);
        check("ovf.sticky", 64'(overflow), 64'd1);

        // rdy stall with requests presented (they must be ignored).
        cyc(1'b1, 1'b1, 1'b1, 32'h5000, 1'b1, 1'b0, 32'h5004);
        cyc(1'b1, 1'b1, 1'b0, 32'h5008, 1'b0, 1'b0, '0);
        expect_out("stall.pre", 1'b1, 1'b1, 32'h5000);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'h5EEE, 1'b1, 1'b1, 32'h5EEC);
            expect_out("stall.hold", 1'b1, 1'b1, 32'h5000);
        end
        idle(); expect_out("stall.r1", 1'b1, 1'b0, 32'h5004);
        idle(); expect_out("stall.r2", 1'b1, 1'b0, 32'h5008);
        idle(); expect_out("stall.empty", 1'b0, 1'b0, 32'h5008);

        // Asynchronous reset between edges with 3 entries queued.
        cyc(1'b1, 1'b1, 1'b1, 32'h6000, 1'b1, 1'b0, 32'h6004);
        cyc(1'b1, 1'b1, 1'b0, 32'h6008, 1'b1, 1'b1, 32'h600C);
        expect_out("areset.pre", 1'b1, 1'b1, 32'h6000);
        #3;
        rst = 1'b0;
        #1;
        expect_out("areset", 1'b0, 1'b0, '0);
        check("areset.acceptRdy", 64'(acceptRdy), 64'd1);
        check("areset.overflow", 64'(overflow), 64'd0);
`ifdef BP_UPDATE_STATS_EN
        check("areset.statTotal", 64'(statTotal), 64'd0);
        check("areset.statMis", 64'(statMis), 64'd0);
`endif
        #3;
        rst = 1'b1;
        idle(); expect_out("post.idle", 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h7000);
        idle(); expect_out("post.issue", 1'b1, 1'b1, 32'h7000);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
